cp2_fdata_outq: RTL and testbench
=================================

CP2_FDATA_OUTQ -- requirements
Module: cp2_fdata_outq

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one fdata word.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries, power of two, minimum 2.
REQ-003 SHALL have parameter TAG_W, default 5: destination register tag width.
REQ-004 SHALL have port clk_  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port decode_as  input  1  arithmetic-store request from decode.
REQ-007 SHALL have port decode_fs  input  1  float-store request from decode.
REQ-008 SHALL have port decode_fdata  input  DATA_W  data word to enqueue.
REQ-009 SHALL have port decode_ftag  input  TAG_W  destination tag to enqueue.
REQ-010 SHALL have port flush  input  1  discard all queued entries.
REQ-011 SHALL have port cp2_frdy  input  1  consumer accepts head entry this cycle.
REQ-012 SHALL have port cp2_fds_0  output  1  head entry valid.
REQ-013 SHALL have port cp2_fdata_0  output  DATA_W  head data.
REQ-014 SHALL have port cp2_ftag_0  output  TAG_W  head tag.
REQ-015 SHALL have port cp2_fkind_0  output  1  head kind: 1 = fs, 0 = as.
REQ-016 SHALL have port cp2_ffull  output  1  queue holds DEPTH entries.
REQ-017 SHALL have port cp2_fovf  output  1  sticky overflow flag.
REQ-018 SHALL have port cp2_fcount  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 SHALL define push request = decode_as OR decode_fs; at most one entry is enqueued per cycle.
REQ-020 SHALL store kind bit = decode_fs; when both decode_as and decode_fs are high, one entry with kind 1 is enqueued.
REQ-021 SHALL define pop = cp2_fds_0 AND cp2_frdy.
REQ-022 SHALL accept a push when count < DEPTH, or when count = DEPTH and pop occurs the same cycle.
REQ-023 SHALL drop a push arriving when full without a simultaneous pop, leave stored contents unchanged, and set cp2_fovf.
REQ-024 SHALL hold cp2_fovf at 1 until flush or reset.
REQ-025 SHALL deliver entries in strict FIFO order; head ports present the entry at the read pointer.
REQ-026 SHALL give latency of one cycle: a push accepted at edge N into an empty queue makes cp2_fds_0 = 1 with that entry after edge N.
REQ-027 SHALL drive cp2_fds_0 = (count != 0) and cp2_ffull = (count == DEPTH).
REQ-028 SHALL force cp2_fdata_0, cp2_ftag_0 and cp2_fkind_0 to 0 whenever cp2_fds_0 = 0.
REQ-029 SHALL hold head outputs stable while cp2_fds_0 = 1 and cp2_frdy = 0.
REQ-030 SHALL leave count unchanged on simultaneous push and pop; both pointers advance.
REQ-031 SHALL ignore cp2_frdy while the queue is empty: no underflow, and the pointers do not move.
REQ-032 SHALL wrap read and write pointers modulo DEPTH.
REQ-033 SHALL give flush priority over push and pop in the same cycle: count, pointers and cp2_fovf are cleared, and the push in that cycle is discarded.

Reset
REQ-034 SHALL, when rst = 1 at a rising edge, clear count, both pointers and cp2_fovf, giving cp2_fds_0 = 0, cp2_ffull = 0, cp2_fcount = 0 and all head outputs 0.
REQ-035 SHALL give rst priority over flush, push and pop; storage array contents need not be cleared.
REQ-036 SHALL, when reset is applied mid-operation, discard all entries; the first push after reset is deliverable one cycle later.

Verification
REQ-037 SHALL cover single push: decode_fs = 1, fdata = 0x3F800000, tag = 3, cp2_frdy = 0 -> next cycle fds = 1, fdata = 0x3F800000, tag = 3, kind = 1, count = 1.
REQ-038 SHALL cover fill and overflow (DEPTH = 4): push 0x1, 0x2, 0x3, 0x4, 0x5 with no ready -> ffull = 1, count = 4, fovf = 1; then frdy held 1 -> pops 0x1..0x4 in order and 0x5 never appears.
REQ-039 SHALL cover full with simultaneous push and pop: count = 4, head 0xA, push 0xE with frdy = 1 -> count stays 4, head becomes the second entry, 0xE is popped fourth, fovf stays 0.
REQ-040 SHALL cover wrap-around: 10 interleaved push/pop pairs with DEPTH = 4 -> output sequence equals input sequence and count never exceeds 1.
REQ-041 SHALL cover flush versus push: count = 3 and fovf = 1, flush = 1 with decode_as = 1 in the same cycle -> count = 0, fds = 0, fovf = 0, head outputs 0.
REQ-042 SHALL cover reset mid-stream: count = 2, rst pulsed one cycle -> all outputs 0; push 0x55 -> fds = 1 with fdata = 0x55 one cycle later.

Source files
------------

// File: rtl/cp2_fdata_outq.sv
// cp2_fdata_outq: fdata output queue between decode and coprocessor 2.
// Decode pushes arithmetic-store or float-store words. The consumer takes the
// head entry with a valid/ready handshake. Head outputs come straight from
// flops, so the next head is chosen one cycle early from the next pointer state.
module cp2_fdata_outq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                   clk_,
    input  logic                   rst,
    input  logic                   decode_as,
    input  logic                   decode_fs,
    input  logic [DATA_W-1:0]      decode_fdata,
    input  logic [TAG_W-1:0]       decode_ftag,
    input  logic                   flush,
    input  logic                   cp2_frdy,
    output logic                   cp2_fds_0,
    output logic [DATA_W-1:0]      cp2_fdata_0,
    output logic [TAG_W-1:0]       cp2_ftag_0,
    output logic                   cp2_fkind_0,
    output logic                   cp2_ffull,
    output logic                   cp2_fovf,
    output logic [$clog2(DEPTH):0] cp2_fcount
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_W + TAG_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry layout is {kind, tag, data}.
    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             ovf_q, ovf_d;
    logic             fds_q, fds_d;
    logic             full_q, full_d;
    logic [ENT_W-1:0] head_q, head_d;

    logic             push_req;
    logic             pop;
    logic             push_ok;
    logic             wr_en;
    logic [ENT_W-1:0] wr_ent;

    // Next-state for occupancy, pointers, overflow flag and the registered head.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        head_d   = '0;

        push_req = decode_as | decode_fs;
        pop      = fds_q & cp2_frdy;
        push_ok  = push_req & ((count_q != FULL_CNT) | pop);
        wr_ent   = {decode_fs, decode_ftag, decode_fdata};

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_req && !push_ok) begin
                ovf_d = 1'b1;
            end
            if (push_ok) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        end

        fds_d  = (count_d != '0);
        full_d = (count_d == FULL_CNT);

        // The slot written this cycle becomes the head only when the queue
        // would otherwise be empty after the pop.
        if (fds_d) begin
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                head_d = wr_ent;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control and head registers with synchronous reset.
    always_ff @(posedge clk_) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            fds_q    <= 1'b0;
            full_q   <= 1'b0;
            head_q   <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            fds_q    <= fds_d;
            full_q   <= full_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are not cleared by reset.
    always_ff @(posedge clk_) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= wr_ent;
        end
    end

    assign cp2_fds_0   = fds_q;
    assign cp2_ffull   = full_q;
    assign cp2_fovf    = ovf_q;
    assign cp2_fcount  = count_q;
    assign cp2_fdata_0 = head_q[DATA_W-1:0];
    assign cp2_ftag_0  = head_q[DATA_W +: TAG_W];
    assign cp2_fkind_0 = head_q[ENT_W-1];

endmodule

// File: tb/tb_cp2_fdata_outq.sv
// Scoreboard bench for cp2_fdata_outq. The stimulus side keeps a reference
// queue of accepted entries. A negedge monitor checks the flags and the head
// against that queue, and it retires an entry on every handshake.
module tb_cp2_fdata_outq;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              kind;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk_;
    logic              rst;
    logic              decode_as;
    logic              decode_fs;
    logic [DATA_W-1:0] decode_fdata;
    logic [TAG_W-1:0]  decode_ftag;
    logic              flush;
    logic              cp2_frdy;
    logic              cp2_fds_0;
    logic [DATA_W-1:0] cp2_fdata_0;
    logic [TAG_W-1:0]  cp2_ftag_0;
    logic              cp2_fkind_0;
    logic              cp2_ffull;
    logic              cp2_fovf;
    logic [CNT_W-1:0]  cp2_fcount;

    cp2_fdata_outq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_        (clk_),
        .rst         (rst),
        .decode_as   (decode_as),
        .decode_fs   (decode_fs),
        .decode_fdata(decode_fdata),
        .decode_ftag (decode_ftag),
        .flush       (flush),
        .cp2_frdy    (cp2_frdy),
        .cp2_fds_0   (cp2_fds_0),
        .cp2_fdata_0 (cp2_fdata_0),
        .cp2_ftag_0  (cp2_ftag_0),
        .cp2_fkind_0 (cp2_fkind_0),
        .cp2_ffull   (cp2_ffull),
        .cp2_fovf    (cp2_fovf),
        .cp2_fcount  (cp2_fcount)
    );

    initial clk_ = 1'b0;
    always #5 clk_ = ~clk_;

    ent_t exp_q[$];
    logic ovf_m  = 1'b0;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   max_cnt = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: compare DUT state to the model and retire the head on a handshake.
    always @(negedge clk_) begin
        if (mon_en) begin
            ent_t e;
            chk("count", longint'(cp2_fcount), longint'(exp_q.size()));
            chk("fds",   longint'(cp2_fds_0), longint'(exp_q.size() != 0));
            chk("ffull", longint'(cp2_ffull), longint'(exp_q.size() == DEPTH));
            chk("fovf",  longint'(cp2_fovf),  longint'(ovf_m));
            if (int'(cp2_fcount) > max_cnt) max_cnt = int'(cp2_fcount);
            if (cp2_fds_0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL head_unexpected: got data 0x%0h expected no entry at %0t",
                             cp2_fdata_0, $time);
                end else begin
                    e = exp_q[0];
                    chk("head_data", longint'(cp2_fdata_0), longint'(e.data));
                    chk("head_tag",  longint'(cp2_ftag_0),  longint'(e.tag));
                    chk("head_kind", longint'(cp2_fkind_0), longint'(e.kind));
                    if (cp2_frdy) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_head", longint'({cp2_fkind_0, cp2_ftag_0, cp2_fdata_0}), 0);
            end
        end
    end

    // Drive one cycle of inputs, then update the model to the post-edge state.
    task automatic step(input logic as, input logic fs, input logic [DATA_W-1:0] d,
                        input logic [TAG_W-1:0] t, input logic rdy, input logic fl,
                        input logic rs);
        int   sz;
        logic acc;
        logic ovs;
        ent_t e;
        decode_as    = as;
        decode_fs    = fs;
        decode_fdata = d;
        decode_ftag  = t;
        cp2_frdy     = rdy;
        flush        = fl;
        rst          = rs;
        sz  = exp_q.size();
        acc = (as | fs) && !fl && !rs && ((sz < int'(DEPTH)) || (rdy && sz != 0));
        ovs = (as | fs) && !fl && !rs && !acc;
        e.kind = fs;
        e.tag  = t;
        e.data = d;
        @(posedge clk_);
        #1;
        if (rs || fl) begin
            exp_q.delete();
            ovf_m = 1'b0;
        end else begin
            if (acc) exp_q.push_back(e);
            if (ovs) ovf_m = 1'b1;
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic push(input logic fs, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                        input logic rdy);
        step(~fs, fs, d, t, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        decode_as = 0; decode_fs = 0; decode_fdata = '0; decode_ftag = '0;
        flush = 0; cp2_frdy = 0; rst = 1;
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        idle(1'b1);

        // Single float-store push, held without ready.
        push(1'b1, 32'h3F80_0000, 5'd3, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill, overflow, then drain.
        for (int i = 1; i <= 5; i++) push(1'b0, DATA_W'(i), TAG_W'(i), 1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Full with a simultaneous push and pop.
        for (int i = 0; i < 4; i++) push(1'b0, DATA_W'(32'hA + i), TAG_W'(i), 1'b0);
        push(1'b1, 32'hE, 5'd9, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Wrap-around with interleaved push/pop; occupancy must stay at most 1.
        max_cnt = 0;
        for (int i = 0; i < 10; i++) push(1'b0, DATA_W'(32'h100 + i), TAG_W'(i), 1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("wrap_max_count", longint'(max_cnt), 1);

        // Reach count 3 with overflow set, then flush together with a push.
        for (int i = 0; i < 5; i++) push(1'b0, DATA_W'(32'h20 + i), TAG_W'(i), 1'b0);
        idle(1'b1);
        step(1'b1, 1'b0, 32'h77, 5'd7, 1'b0, 1'b1, 1'b0);
        idle(1'b0);

        // Reset in mid-stream, then a push is visible one cycle later.
        push(1'b0, 32'h31, 5'd1, 1'b0);
        push(1'b0, 32'h32, 5'd2, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 32'h55, 5'd5, 1'b0);
        idle(1'b1);

        // Both store kinds high at once: one entry, kind 1.
        step(1'b1, 1'b1, 32'hBEEF, 5'd30, 1'b0, 1'b0, 1'b0);
        idle(1'b1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            logic as, fs, rdy, fl, rs;
            as  = ($urandom_range(0, 99) < 40);
            fs  = ($urandom_range(0, 99) < 30);
            rdy = ($urandom_range(0, 99) < 45);
            fl  = ($urandom_range(0, 99) < 3);
            rs  = ($urandom_range(0, 199) < 2);
            step(as, fs, DATA_W'($urandom), TAG_W'($urandom), rdy, fl, rs);
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
